// File: rtl/chess_timer_core_if.sv
// Bundle of the chess clock control pulses and display/status outputs.
// Latency: none; this is wiring only.
// Backpressure: none; pulses are fire-and-forget, outputs are level.
interface chess_timer_core_if;
    logic       TICK;
    logic       START;
    logic       BTN_A;
    logic       BTN_B;
    logic       PAUSE;
    logic [6:0] seg1;
    logic [6:0] seg2;
    logic [6:0] seg3;
    logic [6:0] seg4;
    logic [6:0] seg5;
    logic [6:0] seg6;
    logic [6:0] seg7;
    logic [6:0] seg8;
    logic       ACTIVE_A;
    logic       ACTIVE_B;
    logic       FLAG_A;
    logic       FLAG_B;

    // Stimulus side: drives the pulses, watches the display and status.
    modport master (
        output TICK, START, BTN_A, BTN_B, PAUSE,
        input  seg1, seg2, seg3, seg4, seg5, seg6, seg7, seg8,
        input  ACTIVE_A, ACTIVE_B, FLAG_A, FLAG_B
    );

    // Timer core side.
    modport slave (
        input  TICK, START, BTN_A, BTN_B, PAUSE,
        output seg1, seg2, seg3, seg4, seg5, seg6, seg7, seg8,
        output ACTIVE_A, ACTIVE_B, FLAG_A, FLAG_B
    );
endinterface

// File: rtl/chess_timer_core.sv
// Two-player BCD MM:SS countdown with turn FSM and registered active-low 7-seg digits.
// Latency: state/times/flags/active update on the sampling edge; seg patterns one edge later.
// Backpressure: none; each one-cycle pulse is consumed in the cycle it arrives.
// Optional feature macro: CHESS_INCREMENT_EN (adds INC_SEC to the mover on each accepted switch).
module chess_timer_core #(
    parameter int INIT_MIN = 5,
    parameter int INIT_SEC = 0,
    parameter int INC_SEC  = 2
) (
    input  logic              CLK,
    input  logic              CLR_N,
    chess_timer_core_if.slave bus
);

    typedef struct packed {
        logic [3:0] mt;
        logic [3:0] mu;
        logic [3:0] st;
        logic [3:0] su;
    } bcd_time_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN_A,
        S_RUN_B,
        S_PAUSED,
        S_TIMEOUT
    } state_t;

    localparam bcd_time_t INIT_T = {4'(INIT_MIN / 10), 4'(INIT_MIN % 10),
                                    4'(INIT_SEC / 10), 4'(INIT_SEC % 10)};

    // One BCD step down with borrows; 00:00 is a fixed point.
    function automatic bcd_time_t dec_time(input bcd_time_t t);
        bcd_time_t w_r;
        w_r = t;
        if (t != '0) begin
            if (t.su != 4'd0) begin
                w_r.su = t.su - 4'd1;
            end else begin
                w_r.su = 4'd9;
                if (t.st != 4'd0) begin
                    w_r.st = t.st - 4'd1;
                end else begin
                    w_r.st = 4'd5;
                    if (t.mu != 4'd0) begin
                        w_r.mu = t.mu - 4'd1;
                    end else begin
                        w_r.mu = 4'd9;
                        w_r.mt = t.mt - 4'd1;
                    end
                end
            end
        end
        return w_r;
    endfunction

    // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit.
    function automatic logic [6:0] enc_digit(input logic [3:0] d);
        logic [6:0] w_s;
        case (d)
            4'd0:    w_s = 7'b1000000;
            4'd1:    w_s = 7'b1111001;
            4'd2:    w_s = 7'b0100100;
            4'd3:    w_s = 7'b0110000;
            4'd4:    w_s = 7'b0011001;
            4'd5:    w_s = 7'b0010010;
            4'd6:    w_s = 7'b0000010;
            4'd7:    w_s = 7'b1111000;
            4'd8:    w_s = 7'b0000000;
            4'd9:    w_s = 7'b0010000;
            default: w_s = 7'b1111111;
        endcase
        return w_s;
    endfunction

    // Four digit patterns, minutes tens first.
    function automatic logic [27:0] enc_time(input bcd_time_t t);
        return {enc_digit(t.mt), enc_digit(t.mu), enc_digit(t.st), enc_digit(t.su)};
    endfunction

`ifdef CHESS_INCREMENT_EN
    localparam bcd_time_t SAT_T = {4'd9, 4'd9, 4'd5, 4'd9};

    // Adds INC_SEC with seconds->minutes carry, clamping at 99:59.
    // Small binary detour: each field is at most 118, so the divides are tiny constants.
    function automatic bcd_time_t inc_time(input bcd_time_t t);
        logic [6:0] w_sec;
        logic [6:0] w_min;
        bcd_time_t  w_r;
        w_sec = 7'(t.st) * 7'd10 + 7'(t.su) + 7'(INC_SEC);
        w_min = 7'(t.mt) * 7'd10 + 7'(t.mu);
        if (w_sec >= 7'd60) begin
            w_sec = w_sec - 7'd60;
            w_min = w_min + 7'd1;
        end
        if (w_min > 7'd99) begin
            w_r = SAT_T;
        end else begin
            w_r = {4'(w_min / 7'd10), 4'(w_min % 7'd10),
                   4'(w_sec / 7'd10), 4'(w_sec % 7'd10)};
        end
        return w_r;
    endfunction
`endif

    state_t    r_state;
    state_t    w_state_nxt;
    logic      r_paused_b;
    logic      w_paused_b_nxt;
    bcd_time_t r_time_a;
    bcd_time_t r_time_b;
    bcd_time_t w_time_a_nxt;
    bcd_time_t w_time_b_nxt;
    logic      r_flag_a;
    logic      r_flag_b;
    logic      w_flag_a_nxt;
    logic      w_flag_b_nxt;
    logic      r_active_a;
    logic      r_active_b;
    logic [27:0] r_seg_a;
    logic [27:0] r_seg_b;

    bcd_time_t w_dec_a;
    bcd_time_t w_dec_b;
    bcd_time_t w_tick_a;
    bcd_time_t w_tick_b;
    bcd_time_t w_sw_a;
    bcd_time_t w_sw_b;

    // Tick-adjusted time of each side, and that time after a turn-switch bonus.
    assign w_dec_a  = dec_time(r_time_a);
    assign w_dec_b  = dec_time(r_time_b);
    assign w_tick_a = bus.TICK ? w_dec_a : r_time_a;
    assign w_tick_b = bus.TICK ? w_dec_b : r_time_b;
`ifdef CHESS_INCREMENT_EN
    assign w_sw_a   = inc_time(w_tick_a);
    assign w_sw_b   = inc_time(w_tick_b);
`else
    logic w_unused_inc;
    assign w_unused_inc = ^INC_SEC;
    assign w_sw_a   = w_tick_a;
    assign w_sw_b   = w_tick_b;
`endif

    // Next state: START wins, then timeout, then button, then pause.
    always_comb begin
        w_state_nxt    = r_state;
        w_paused_b_nxt = r_paused_b;
        w_time_a_nxt   = r_time_a;
        w_time_b_nxt   = r_time_b;
        w_flag_a_nxt   = r_flag_a;
        w_flag_b_nxt   = r_flag_b;
        if (bus.START) begin
            w_time_a_nxt   = INIT_T;
            w_time_b_nxt   = INIT_T;
            w_flag_a_nxt   = 1'b0;
            w_flag_b_nxt   = 1'b0;
            w_paused_b_nxt = 1'b0;
            w_state_nxt    = (r_state == S_IDLE) ? S_RUN_A : S_IDLE;
        end else begin
            case (r_state)
                S_RUN_A: begin
                    if (bus.TICK && (w_dec_a == '0)) begin
                        w_time_a_nxt = w_dec_a;
                        w_flag_a_nxt = 1'b1;
                        w_state_nxt  = S_TIMEOUT;
                    end else begin
                        w_time_a_nxt = bus.BTN_A ? w_sw_a : w_tick_a;
                        if (bus.BTN_A) w_state_nxt = S_RUN_B;
                        if (bus.PAUSE) begin
                            w_paused_b_nxt = bus.BTN_A;
                            w_state_nxt    = S_PAUSED;
                        end
                    end
                end
                S_RUN_B: begin
                    if (bus.TICK && (w_dec_b == '0)) begin
                        w_time_b_nxt = w_dec_b;
                        w_flag_b_nxt = 1'b1;
                        w_state_nxt  = S_TIMEOUT;
                    end else begin
                        w_time_b_nxt = bus.BTN_B ? w_sw_b : w_tick_b;
                        if (bus.BTN_B) w_state_nxt = S_RUN_A;
                        if (bus.PAUSE) begin
                            w_paused_b_nxt = !bus.BTN_B;
                            w_state_nxt    = S_PAUSED;
                        end
                    end
                end
                S_PAUSED: begin
                    if (bus.PAUSE) w_state_nxt = r_paused_b ? S_RUN_B : S_RUN_A;
                end
                default: begin
                end
            endcase
        end
    end

    // State, times, flags and running indicators.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            r_state    <= S_IDLE;
            r_paused_b <= 1'b0;
            r_time_a   <= INIT_T;
            r_time_b   <= INIT_T;
            r_flag_a   <= 1'b0;
            r_flag_b   <= 1'b0;
            r_active_a <= 1'b0;
            r_active_b <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_paused_b <= w_paused_b_nxt;
            r_time_a   <= w_time_a_nxt;
            r_time_b   <= w_time_b_nxt;
            r_flag_a   <= w_flag_a_nxt;
            r_flag_b   <= w_flag_b_nxt;
            r_active_a <= (w_state_nxt == S_RUN_A);
            r_active_b <= (w_state_nxt == S_RUN_B);
        end
    end

    // Display patterns follow the time registers one edge behind.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            r_seg_a <= enc_time(INIT_T);
            r_seg_b <= enc_time(INIT_T);
        end else begin
            r_seg_a <= enc_time(r_time_a);
            r_seg_b <= enc_time(r_time_b);
        end
    end

    assign bus.seg1     = r_seg_a[27:21];
    assign bus.seg2     = r_seg_a[20:14];
    assign bus.seg3     = r_seg_a[13:7];
    assign bus.seg4     = r_seg_a[6:0];
    assign bus.seg5     = r_seg_b[27:21];
    assign bus.seg6     = r_seg_b[20:14];
    assign bus.seg7     = r_seg_b[13:7];
    assign bus.seg8     = r_seg_b[6:0];
    assign bus.ACTIVE_A = r_active_a;
    assign bus.ACTIVE_B = r_active_b;
    assign bus.FLAG_A   = r_flag_a;
    assign bus.FLAG_B   = r_flag_b;

endmodule
